// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: button sync/debounce, IDLE/RUN/PAUSED FSM,
// 1 Hz run-gated tick and one-cycle clear pulse for the counter.
module stopwatch_ctrl #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic       run,
  output logic       sec_tick,
  output logic       clear,
  output logic [1:0] state
);

  localparam int PW =
    (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int DW =
    (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(CLK_FREQ - 1);
  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  // bit 0: start/stop, bit 1: clear
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    lvl;
  logic [1:0]    lvl_q;
  logic [1:0]    press;
  logic [DW-1:0] cnt [2];

  logic ss_p;
  logic clr_p;

  state_t        state_q;
  state_t        state_d;
  logic          clear_q;
  logic          clear_d;
  logic          tick_q;
  logic          tick_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  assign raw = {btn_clear, btn_start_stop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          lvl[i] <= ~lvl[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  // Only the 0->1 edge of the accepted level counts
  assign press = lvl & ~lvl_q;
  assign ss_p  = press[0];
  assign clr_p = press[1];

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (clr_p) begin
          clear_d = 1'b1;
        end else if (ss_p) begin
          state_d = RUN;
        end
      end
      (state_q == RUN): begin
        if (ss_p) begin
          state_d = PAUSED;
        end
      end
      (state_q == PAUSED): begin
        if (clr_p) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end else if (ss_p) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Prescaler holds in PAUSED so a resume keeps the partial second
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (state_q == RUN) begin
      tick_d = (presc_q == PRE_LAST);
      if (tick_d) begin
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (state_q != PAUSED) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      clear_q <= 1'b0;
      tick_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
      tick_q  <= tick_d;
      presc_q <= presc_d;
    end
  end

  assign run      = (state_q == RUN);
  assign sec_tick = tick_q;
  assign clear    = clear_q;
  assign state    = state_q;

endmodule
